// File: rtl/grid_pkg.sv
// Object codes and grid geometry shared by the grid arbiter and the static sprite renderer.
package grid_pkg;
    localparam int GRID_ROWS = 8;
    localparam int GRID_COLS = 13;

    typedef logic [3:0] obj_t;
    typedef obj_t [7:0][12:0] grid_t;

    localparam obj_t G_EMPTY          = 4'd0;
    localparam obj_t G_ONION_WHOLE    = 4'd1;
    localparam obj_t G_ONION_CHOPPED  = 4'd2;
    localparam obj_t G_TOMATO_WHOLE   = 4'd3;
    localparam obj_t G_TOMATO_CHOPPED = 4'd4;
    localparam obj_t G_PLATE          = 4'd5;
    localparam obj_t G_POT            = 4'd6;
    localparam obj_t G_SOUP           = 4'd7;
    localparam obj_t G_DIRTY_PLATE    = 4'd8;
    localparam obj_t G_FIRE           = 4'd9;
    localparam obj_t G_EXTINGUISHER   = 4'd10;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from last+1.
module rr_arbiter #(
    parameter int N = 4,
    localparam int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          pixel_clk_in,
    input  logic          rst_in,
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic          accept,
    output logic [N-1:0]  gnt,
    output logic [LW-1:0] last
);
    logic [LW-1:0] idx;
    logic [LW-1:0] gnt_idx;
    logic          found;

    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        idx     = '0;
        gnt_idx = last;
        for (int i = 1; i <= N; i++) begin
            idx = LW'((32'(last) + i) % N);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

    // Reset to N-1 so requester 0 is first in line.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in)
            last <= LW'(N - 1);
        else if (accept)
            last <= gnt_idx;
    end
endmodule

// File: rtl/object_grid_arbiter.sv
// Kitchen object grid: round-robin serialised compare-and-swap writes into a working grid,
// copied to the display grid only on frame start.
module object_grid_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int GRID_ROWS = 8,
    parameter int GRID_COLS = 13,
    parameter int OBJ_W     = 4
) (
    input  logic                                         pixel_clk_in,
    input  logic                                         rst_in,
    input  logic                                         frame_start_in,
    input  logic                                         pause_in,
    input  logic [NUM_REQ-1:0]                           req_valid_in,
    input  logic [NUM_REQ-1:0][3:0]                      req_x_in,
    input  logic [NUM_REQ-1:0][2:0]                      req_y_in,
    input  logic [NUM_REQ-1:0][OBJ_W-1:0]                req_expect_in,
    input  logic [NUM_REQ-1:0][OBJ_W-1:0]                req_obj_in,
    output logic [NUM_REQ-1:0]                           req_ready_out,
    output logic [NUM_REQ-1:0]                           resp_valid_out,
    output logic [NUM_REQ-1:0]                           resp_ok_out,
    output logic [GRID_ROWS-1:0][GRID_COLS-1:0][OBJ_W-1:0] object_grid_out,
    output logic [GRID_ROWS-1:0][GRID_COLS-1:0][OBJ_W-1:0] work_grid_out
);
    import grid_pkg::G_EMPTY;

    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [GRID_ROWS-1:0][GRID_COLS-1:0][OBJ_W-1:0] work;
    logic [GRID_ROWS-1:0][GRID_COLS-1:0][OBJ_W-1:0] disp;
    logic [NUM_REQ-1:0] gnt;
    logic [LW-1:0]      last;
    logic [NUM_REQ-1:0] resp_v;
    logic [NUM_REQ-1:0] resp_ok;
    logic               accept;

    logic [3:0]       sel_x;
    logic [2:0]       sel_y;
    logic [OBJ_W-1:0] sel_expect;
    logic [OBJ_W-1:0] sel_obj;
    logic [31:0]      xx, yy;
    logic [OBJ_W-1:0] cur;
    logic             in_range;
    logic             ok;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .req          (req_valid_in),
        .en           (!pause_in && !rst_in),
        .accept       (accept),
        .gnt          (gnt),
        .last         (last)
    );

    assign accept = |gnt;

    // Grant is one-hot, so OR-ing the masked fields selects the winner.
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_expect = '0;
        sel_obj    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_x      = sel_x | req_x_in[i];
                sel_y      = sel_y | req_y_in[i];
                sel_expect = sel_expect | req_expect_in[i];
                sel_obj    = sel_obj | req_obj_in[i];
            end
        end
    end

    always_comb begin
        xx       = 32'(sel_x);
        yy       = 32'(sel_y);
        in_range = (xx < 32'(GRID_COLS)) && (yy < 32'(GRID_ROWS));
        cur      = in_range ? work[sel_y][sel_x] : '0;
        ok       = in_range && (cur == sel_expect);
    end

    // disp samples work before this edge's write, so a same-cycle write waits a frame.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            work    <= {GRID_ROWS*GRID_COLS{OBJ_W'(G_EMPTY)}};
            disp    <= {GRID_ROWS*GRID_COLS{OBJ_W'(G_EMPTY)}};
            resp_v  <= '0;
            resp_ok <= '0;
        end else begin
            if (frame_start_in)
                disp <= work;
            if (accept && ok)
                work[sel_y][sel_x] <= sel_obj;
            resp_v  <= gnt;
            resp_ok <= ok ? gnt : '0;
        end
    end

    assign req_ready_out   = gnt;
    // A response registered just before reset is dropped rather than delivered.
    assign resp_valid_out  = rst_in ? '0 : resp_v;
    assign resp_ok_out     = rst_in ? '0 : resp_ok;
    assign object_grid_out = disp;
    assign work_grid_out   = work;
endmodule

// File: doc/object_grid_arbiter.md
# object_grid_arbiter

- Owns the kitchen object grid that the static sprite renderer reads.
- Serialises grid write requests from all requesters (player controllers, pot cook timers, fire spreader) through a round-robin arbiter.
- Each write is a compare-and-swap, so exactly one requester wins any contested square (for example, two players grabbing the same onion).
- The renderer-facing copy of the grid updates only on a frame-start pulse, so a frame never shows a half-applied set of updates.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters.
- GRID_ROWS, default 8: grid rows (y).
- GRID_COLS, default 13: grid columns (x).
- OBJ_W, default 4: width of an object code.

Ports:
- pixel_clk_in  input  1: the single clock.
- rst_in  input  1: synchronous, active-high reset.
- frame_start_in  input  1: one-cycle pulse at the start of vertical blanking.
- pause_in  input  1: while high, no grants are issued.
- req_valid_in  input  [NUM_REQ]: request pending. Held until granted.
- req_x_in  input  [NUM_REQ][3:0]: target column.
- req_y_in  input  [NUM_REQ][2:0]: target row.
- req_expect_in  input  [NUM_REQ][OBJ_W-1:0]: object code required at the target square for the write to succeed.
- req_obj_in  input  [NUM_REQ][OBJ_W-1:0]: object code to write.
- req_ready_out  output  [NUM_REQ]: grant. One-hot or zero. Combinational.
- resp_valid_out  output  [NUM_REQ]: one-cycle result pulse.
- resp_ok_out  output  [NUM_REQ]: write succeeded. Qualified by resp_valid_out.
- object_grid_out  output  [GRID_ROWS-1:0][GRID_COLS-1:0][OBJ_W-1:0]: committed display grid.
- work_grid_out  output  same shape as object_grid_out: working grid, for game logic lookups.

## Operation
**Grid state**
- Two grid registers: the working grid (`work`) and the display grid (`disp`).
- Reset sets both grids to all G_EMPTY (0).

**Arbitration**
- A round-robin pointer `last` records the most recently granted index. It resets to NUM_REQ-1, so requester 0 has first priority after reset.
- When pause_in=0 and rst_in=0, the arbiter grants the first valid requester, searching from index last+1 upward with wrap-around.
  - That requester sees req_ready_out high.
  - The transfer happens on the clock edge where valid and ready are both high.
  - `last` updates to the granted index.
- With no valid requester, no grant is issued and `last` is unchanged.

**Accepted request**
- The request succeeds (ok=1) only when both hold:
  - it is in range: x<GRID_COLS and y<GRID_ROWS;
  - `work[y][x]` equals req_expect_in.
- On success, `work[y][x]` ← req_obj_in at the same edge.
- On failure, `work` is unchanged.
- Out-of-range coordinates always fail.

**Commit**
- On a frame_start_in edge, `disp` ← `work` as registered before that cycle's write.
- A write accepted in the same cycle lands in `work` only and appears in `disp` at the next frame_start_in.

**Reset mid-operation**
- Reset clears both grids and `last`, and forces resp_valid_out to 0.
- An in-flight response is dropped. The requester must re-issue its request after reset.

## Timing
**Latency and outputs**
- Grant is combinational from req_valid_in, pause_in and `last`.
- Response: resp_valid_out[i] pulses exactly one cycle after acceptance, with resp_ok_out[i] valid in that cycle.
- At most one response bit is set per cycle.

**Read-after-write**
- A write accepted at edge t is visible on work_grid_out from t+1.
- The compare for a request accepted at edge t+1 sees that write, so back-to-back CAS operations on the same square are correctly ordered.

**Throughput**
- One request per cycle.
- With k requesters continuously valid, each is granted once every k cycles. No starvation.

**Display and pause**
- object_grid_out changes only on the edge after frame_start_in, or on reset.
- pause_in high means req_ready_out is 0 in that cycle. A response already registered is still delivered.

**Reset values**
- req_ready_out=0 while rst_in=1.
- resp_valid_out=0, resp_ok_out=0, both grids all-zero.

## Structure
**Package grid_pkg**
- G_* object codes: G_EMPTY=0 through G_EXTINGUISHER=10.
- GRID_ROWS and GRID_COLS.
- typedef obj_t: logic [3:0].
- typedef grid_t: obj_t [7:0][12:0].
- The static sprite renderer imports the same package.

**Sub-module rr_arbiter**
- Parameter N.
- Inputs: pixel_clk_in, rst_in, req, en, accept.
- Outputs: one-hot gnt, and the `last` pointer update.
- The CAS compare, write and commit logic stay in object_grid_arbiter.

## Test plan
- **Reset defaults:** after reset, all outputs are zero and both grids read G_EMPTY. A frame_start_in pulse leaves object_grid_out unchanged.
- **Contested square:**
  - Setup: `work[2][5]`=1 (G_ONION_WHOLE).
  - Stimulus: req0 and req1 both present expect=1, obj=0 for (5,2) in the same cycle.
  - Required response: req0 is granted first with ok=1; req1 is granted the next cycle with ok=0; `work[2][5]`=0.
- **Fairness:** all four requesters held valid for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3.
- **Out-of-range and mismatch:**
  - x=13 -> ok=0, no grid change.
  - expect=3 against a square holding 0 -> ok=0.
- **Commit timing:**
  - Write G_FIRE (9) to (0,0) at cycle 10.
  - frame_start_in pulses at cycle 20.
  - Required response: object_grid_out[0][0] reads 0 until cycle 20 and reads 9 from cycle 21.
  - Second case: a write accepted in the same cycle as frame_start_in appears only after the following frame_start_in.
- **Pause and reset mid-stream:**
  - pause_in high for 3 cycles with req2 valid -> no grant during those cycles; req2 is granted the cycle after pause_in drops.
  - Reset asserted in the cycle after an accept -> no resp_valid_out pulse, grids cleared.
